meduram_cell: RTL and testbench
===============================

Name: meduram_cell

Overview:
- Single storage word of the multi-agent RAM, located at address CELL_ADDR_VALUE is not a parameter; address comes from the cell_addr port.
- Accepts writes from NB_WRAGENT agents and serves reads to NB_RDAGENT agents.
- Resolves simultaneous same-address writes deterministically and counts collisions.
- Read outputs are zero when not selected, so the read buses of all cells are OR-reduced at the top level.

Parameters:
- ADDR_WIDTH, 8, write/read address width.
- DATA_WIDTH, 32, word width.
- NB_WRAGENT, 2, number of write agents (>=1).
- NB_RDAGENT, 2, number of read agents (>=1).
- CNT_WIDTH, 8, collision counter width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- cell_addr  in  ADDR_WIDTH  address owned by this cell (static).
- wren  in  NB_WRAGENT  per-agent write enable.
- wraddr  in  NB_WRAGENT*ADDR_WIDTH  packed write addresses, agent i at [i*ADDR_WIDTH+:ADDR_WIDTH].
- wrdata  in  NB_WRAGENT*DATA_WIDTH  packed write data.
- rden  in  NB_RDAGENT  per-agent read enable.
- rdaddr  in  NB_RDAGENT*ADDR_WIDTH  packed read addresses.
- rdvalid  out  NB_RDAGENT  per-agent read data valid.
- rddata  out  NB_RDAGENT*DATA_WIDTH  packed read data.
- clr  in  1  synchronous clear of the collision status.
- collision  out  1  sticky collision flag.
- collision_cnt  out  CNT_WIDTH  saturating collision count.

Interface (already decided):
- One clock, aclk.
- Reset aresetn is asynchronous and active-low.

Behaviour:
- Reset values: storage word 0, rdvalid 0, rddata 0, collision 0, collision_cnt 0.
- Write hit for agent i: wren[i]=1 and wraddr slice i == cell_addr.
- Write arbitration:
  - Lowest-index hitting agent wins.
  - Its wrdata slice is stored at the next rising edge.
  - With no hits, the word holds its value.
- Collision: two or more write hits in the same cycle.
  - Next edge: collision is set to 1.
  - collision_cnt increments by 1 and saturates at 2^CNT_WIDTH-1 (no wrap).
- clr=1 clears collision and collision_cnt at the next edge.
  - If clr and a collision occur in the same cycle, the collision wins: flag=1, cnt=1.
- Read hit for agent j: rden[j]=1 and rdaddr slice j == cell_addr.
  - Latency 1: at the next edge rdvalid[j]=1 and rddata slice j = word value.
  - Otherwise rdvalid[j]=0 and rddata slice j = 0.
  - Outputs are registered.
- Read and write to this cell in the same cycle return the OLD word (read-first), unless the optional feature is enabled.
- All read agents may hit in the same cycle; there is no read arbitration and no read stall.
- Reset asserted mid-operation: all state returns to reset values immediately; pending read responses are dropped (rdvalid=0).
- Address compare is full-width equality; no partial decode.

Optional Feature:
- Macro: MEDURAM_WRITE_FORWARD_EN.
- Defined: write-first.
  - A read hit coinciding with a write hit returns the winning agent's wrdata on the next cycle.
  - This is the same value the storage word holds after that edge.
- Undefined: read-first, as in Behaviour.
- Collision handling is identical in both builds.

Test Plan:
1. Reset, then read agent 0 at cell_addr=0x10 -> next cycle: rdvalid=2'b01, rddata0=0x00000000, rddata1=0.
2. Write agent 1 writes 0xDEADBEEF to 0x10, then both agents read 0x10 -> next cycle: rdvalid=2'b11, both slices 0xDEADBEEF, collision=0.
3. Both agents write 0x10 in one cycle (agent0 0x11111111, agent1 0x22222222) -> word=0x11111111, collision=1, collision_cnt=1; writes to 0x11 leave the cell unchanged.
4. Apply CNT_WIDTH=2 and 5 collision cycles -> collision_cnt sequence 1,2,3,3,3; clr alone -> 0/0; clr with a collision in the same cycle -> flag 1, cnt 1.
5. Same-cycle write 0xCAFE0000 and read of 0x10 with word 0x11111111 -> rddata=0x11111111 without the macro, 0xCAFE0000 with MEDURAM_WRITE_FORWARD_EN.
6. aresetn low while a read is in flight -> rdvalid=0, rddata=0, word=0 immediately (asynchronous); first read after release returns 0.

Source files
------------

// File: rtl/meduram_cell.sv
// meduram_cell: one storage word of the multi-agent RAM. Lowest-index write hit wins, collisions are
// counted, and every read agent gets a registered, zero-when-idle response. MEDURAM_WRITE_FORWARD_EN selects write-first reads.

module meduram_rdlane #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] cell_addr,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddr,
  input  logic [DATA_WIDTH-1:0] rdsrc,
  output logic                  rdvalid,
  output logic [DATA_WIDTH-1:0] rddata
);
  logic hit;
  assign hit = rden && (rdaddr == cell_addr);

  // Idle lanes drive zero so the top level can OR all cells together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdvalid <= 1'b0;
      rddata  <= '0;
    end else begin
      rdvalid <= hit;
      rddata  <= hit ? rdsrc : '0;
    end
  end
endmodule

module meduram_cell #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NB_WRAGENT = 2,
  parameter int NB_RDAGENT = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [ADDR_WIDTH-1:0]            cell_addr,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
  input  logic [NB_RDAGENT-1:0]            rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
  output logic [NB_RDAGENT-1:0]            rdvalid,
  output logic [NB_RDAGENT*DATA_WIDTH-1:0] rddata,
  input  logic                             clr,
  output logic                             collision,
  output logic [CNT_WIDTH-1:0]             collision_cnt
);
  logic [DATA_WIDTH-1:0] word, wrsel, rdsrc;
  logic [NB_WRAGENT-1:0] wrhit;
  logic                  anyhit, multi;

  for (genvar i = 0; i < NB_WRAGENT; i++) begin : g_wrhit
    assign wrhit[i] = wren[i] && (wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == cell_addr);
  end

  // Ascending scan: the first hit claims the write, any later hit flags a collision.
  always_comb begin
    wrsel  = '0;
    anyhit = 1'b0;
    multi  = 1'b0;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      if (wrhit[i]) begin
        if (anyhit) multi = 1'b1;
        else        wrsel = wrdata[i*DATA_WIDTH +: DATA_WIDTH];
        anyhit = 1'b1;
      end
    end
  end

`ifdef MEDURAM_WRITE_FORWARD_EN
  assign rdsrc = anyhit ? wrsel : word;
`else
  assign rdsrc = word;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    word <= '0;
    else if (anyhit) word <= wrsel;
  end

  // A collision in the clearing cycle restarts the count at one rather than being lost.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      collision     <= 1'b0;
      collision_cnt <= '0;
    end else if (multi) begin
      collision <= 1'b1;
      if (clr)                     collision_cnt <= CNT_WIDTH'(1);
      else if (collision_cnt != '1) collision_cnt <= collision_cnt + 1'b1;
    end else if (clr) begin
      collision     <= 1'b0;
      collision_cnt <= '0;
    end
  end

  for (genvar j = 0; j < NB_RDAGENT; j++) begin : g_rd
    meduram_rdlane #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rdlane (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .cell_addr (cell_addr),
      .rden      (rden[j]),
      .rdaddr    (rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]),
      .rdsrc     (rdsrc),
      .rdvalid   (rdvalid[j]),
      .rddata    (rddata[j*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_meduram_cell.sv
// Bench for meduram_cell: a behavioural model pushes expected responses to a queue as each
// cycle is driven; test tasks pop and compare after the edge. A CNT_WIDTH=2 copy covers saturation.

module tb_meduram_cell;
  localparam logic [7:0] CELL = 8'h10;

  logic        aclk = 1'b0, aresetn = 1'b0, clr = 1'b0;
  logic [1:0]  wren = '0, rden = '0;
  logic [15:0] wraddr = '0, rdaddr = '0;
  logic [63:0] wrdata = '0;
  logic [1:0]  rdvalid, rdvalid2;
  logic [63:0] rddata, rddata2;
  logic        collision, collision2;
  logic [7:0]  collision_cnt;
  logic [1:0]  collision_cnt2;

  typedef struct { logic [1:0] v; logic [63:0] d; logic c; logic [7:0] n; } exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] m_word = '0;
  logic        m_coll = 1'b0;
  logic [7:0]  m_cnt  = '0;
  int n_cmp = 0, n_bad = 0;

  meduram_cell dut (
    .aclk(aclk), .aresetn(aresetn), .cell_addr(CELL),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .rden(rden), .rdaddr(rdaddr), .rdvalid(rdvalid), .rddata(rddata),
    .clr(clr), .collision(collision), .collision_cnt(collision_cnt)
  );

  meduram_cell #(.CNT_WIDTH(2)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .cell_addr(CELL),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
    .rden(rden), .rdaddr(rdaddr), .rdvalid(rdvalid2), .rddata(rddata2),
    .clr(clr), .collision(collision2), .collision_cnt(collision_cnt2)
  );

  always #5 aclk = ~aclk;

  // Drive one cycle, push the model's expectation, advance to just after the edge.
  task automatic cyc(input logic [1:0] we, input logic [7:0] wa0, input logic [7:0] wa1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic [1:0] re, input logic [7:0] ra0, input logic [7:0] ra1,
                     input logic c);
    exp_t x;
    logic [1:0]  wh;
    logic [31:0] ws, rv;
    wren = we; wraddr = {wa1, wa0}; wrdata = {wd1, wd0};
    rden = re; rdaddr = {ra1, ra0}; clr = c;
    wh[0] = we[0] && wa0 == CELL;
    wh[1] = we[1] && wa1 == CELL;
    ws = wh[0] ? wd0 : wd1;
`ifdef MEDURAM_WRITE_FORWARD_EN
    rv = (|wh) ? ws : m_word;
`else
    rv = m_word;
`endif
    x.v = '0; x.d = '0;
    if (re[0] && ra0 == CELL) begin x.v[0] = 1'b1; x.d[31:0]  = rv; end
    if (re[1] && ra1 == CELL) begin x.v[1] = 1'b1; x.d[63:32] = rv; end
    if (&wh) begin
      m_coll = 1'b1;
      m_cnt  = c ? 8'd1 : (m_cnt == 8'hFF ? m_cnt : m_cnt + 8'd1);
    end else if (c) begin
      m_coll = 1'b0; m_cnt = '0;
    end
    x.c = m_coll; x.n = m_cnt;
    if (|wh) m_word = ws;
    q.push_back(x);
    @(posedge aclk); #1;
    wren = '0; rden = '0; clr = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({rdvalid, rddata, collision, collision_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset: got v=%b d=%h c=%b n=%0d, want all zero", rdvalid, rddata, collision, collision_cnt);
    end
  endtask

  task automatic test_read_zero();
    cyc(2'b00, 8'h0, 8'h0, 0, 0, 2'b01, CELL, 8'h0, 1'b0);
    e = q.pop_front(); n_cmp++;
    if (rdvalid !== 2'b01 || rddata !== 64'h0 || {rdvalid, rddata} !== {e.v, e.d}) begin
      n_bad++;
      $display("FAIL read_zero: got v=%b d=%h, want v=01 d=0", rdvalid, rddata);
    end
  endtask

  task automatic test_write_read();
    cyc(2'b10, 8'h0, CELL, 0, 32'hDEADBEEF, 2'b00, 8'h0, 8'h0, 1'b0);
    void'(q.pop_front());
    cyc(2'b00, 8'h0, 8'h0, 0, 0, 2'b11, CELL, CELL, 1'b0);
    e = q.pop_front(); n_cmp++;
    if (rdvalid !== 2'b11 || rddata !== 64'hDEADBEEF_DEADBEEF || collision !== 1'b0 ||
        {rdvalid, rddata, collision, collision_cnt} !== {e.v, e.d, e.c, e.n}) begin
      n_bad++;
      $display("FAIL write_read: got v=%b d=%h c=%b, want v=11 d=deadbeefdeadbeef c=0", rdvalid, rddata, collision);
    end
  endtask

  task automatic test_collision();
    cyc(2'b11, CELL, CELL, 32'h11111111, 32'h22222222, 2'b00, 8'h0, 8'h0, 1'b0);
    e = q.pop_front(); n_cmp++;
    if (collision !== 1'b1 || collision_cnt !== 8'd1 || {collision, collision_cnt} !== {e.c, e.n}) begin
      n_bad++;
      $display("FAIL collision: got c=%b n=%0d, want c=1 n=1", collision, collision_cnt);
    end
    cyc(2'b11, 8'h11, 8'h11, 32'h33333333, 32'h44444444, 2'b00, 8'h0, 8'h0, 1'b0);
    void'(q.pop_front());
    cyc(2'b00, 8'h0, 8'h0, 0, 0, 2'b11, CELL, CELL, 1'b0);
    e = q.pop_front(); n_cmp++;
    if (rddata !== 64'h11111111_11111111 || collision_cnt !== 8'd1 || rddata !== e.d) begin
      n_bad++;
      $display("FAIL collision_word: got d=%h n=%0d, want d=1111111111111111 n=1", rddata, collision_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    cyc(2'b00, 8'h0, 8'h0, 0, 0, 2'b00, 8'h0, 8'h0, 1'b1);
    void'(q.pop_front());
    for (int k = 0; k < 5; k++) begin
      cyc(2'b11, CELL, CELL, 32'h11111111, 32'h22222222, 2'b00, 8'h0, 8'h0, 1'b0);
      e = q.pop_front(); n_cmp++;
      if (collision_cnt2 !== seq[k] || collision2 !== 1'b1 || {collision, collision_cnt} !== {e.c, e.n}) begin
        n_bad++;
        $display("FAIL sat_%0d: got n2=%0d c2=%b n=%0d, want n2=%0d c2=1 n=%0d", k, collision_cnt2, collision2, collision_cnt, seq[k], e.n);
      end
    end
    cyc(2'b00, 8'h0, 8'h0, 0, 0, 2'b00, 8'h0, 8'h0, 1'b1);
    e = q.pop_front(); n_cmp++;
    if ({collision2, collision_cnt2} !== 3'b000 || {collision, collision_cnt} !== {e.c, e.n}) begin
      n_bad++;
      $display("FAIL clr: got c2=%b n2=%0d c=%b n=%0d, want all zero", collision2, collision_cnt2, collision, collision_cnt);
    end
    cyc(2'b11, CELL, CELL, 32'h11111111, 32'h22222222, 2'b00, 8'h0, 8'h0, 1'b0);
    void'(q.pop_front());
    cyc(2'b11, CELL, CELL, 32'h11111111, 32'h22222222, 2'b00, 8'h0, 8'h0, 1'b1);
    e = q.pop_front(); n_cmp++;
    if ({collision2, collision_cnt2} !== 3'b101 || {collision, collision_cnt} !== {1'b1, 8'd1} ||
        {collision, collision_cnt} !== {e.c, e.n}) begin
      n_bad++;
      $display("FAIL clr_vs_coll: got c=%b n=%0d c2=%b n2=%0d, want 1/1", collision, collision_cnt, collision2, collision_cnt2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
`ifdef MEDURAM_WRITE_FORWARD_EN
    want = 32'hCAFE0000;
`else
    want = 32'h11111111;
`endif
    cyc(2'b01, CELL, 8'h0, 32'hCAFE0000, 0, 2'b11, CELL, CELL, 1'b0);
    e = q.pop_front(); n_cmp++;
    if (rddata !== {want, want} || rdvalid !== 2'b11 || rddata !== e.d) begin
      n_bad++;
      $display("FAIL same_cycle: got d=%h, want %h%h", rddata, want, want);
    end
    cyc(2'b00, 8'h0, 8'h0, 0, 0, 2'b10, 8'h0, CELL, 1'b0);
    e = q.pop_front(); n_cmp++;
    if (rdvalid !== 2'b10 || rddata !== 64'hCAFE0000_00000000 || rddata !== e.d) begin
      n_bad++;
      $display("FAIL after_write: got v=%b d=%h, want v=10 d=cafe000000000000", rdvalid, rddata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [4];
    for (int k = 0; k < 40; k++) begin
      for (int m = 0; m < 4; m++) a[m] = ($urandom_range(0, 2) != 0) ? CELL : 8'h11;
      cyc(2'($urandom), a[0], a[1], $urandom, $urandom, 2'($urandom), a[2], a[3], ($urandom_range(0, 7) == 0));
      e = q.pop_front(); n_cmp++;
      if ({rdvalid, rddata, collision, collision_cnt} !== {e.v, e.d, e.c, e.n}) begin
        n_bad++;
        $display("FAIL b2b_%0d: got v=%b d=%h c=%b n=%0d, want v=%b d=%h c=%b n=%0d", k,
                 rdvalid, rddata, collision, collision_cnt, e.v, e.d, e.c, e.n);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(2'b01, CELL, 8'h0, 32'h5A5A5A5A, 0, 2'b00, 8'h0, 8'h0, 1'b0);
    void'(q.pop_front());
    cyc(2'b00, 8'h0, 8'h0, 0, 0, 2'b11, CELL, CELL, 1'b0);
    void'(q.pop_front());
    #2 aresetn = 1'b0;
    #1 n_cmp++;
    if ({rdvalid, rddata, collision, collision_cnt, rdvalid2, rddata2} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b d=%h c=%b n=%0d, want all zero", rdvalid, rddata, collision, collision_cnt);
    end
    m_word = '0; m_coll = 1'b0; m_cnt = '0;
    @(posedge aclk); #1 aresetn = 1'b1;
    cyc(2'b00, 8'h0, 8'h0, 0, 0, 2'b11, CELL, CELL, 1'b0);
    e = q.pop_front(); n_cmp++;
    if (rdvalid !== 2'b11 || rddata !== 64'h0 || {rdvalid, rddata} !== {e.v, e.d}) begin
      n_bad++;
      $display("FAIL post_reset_read: got v=%b d=%h, want v=11 d=0", rdvalid, rddata);
    end
  endtask

  initial begin
    #12 test_reset();
    aresetn = 1'b1;
    @(posedge aclk); #1;
    test_read_zero();
    test_write_read();
    test_collision();
    test_saturation();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
